// File: rtl/seven_segment_mux_driver_pkg.sv
// rtl/seven_segment_mux_driver_pkg.sv - seven-segment types, constants and hex glyph table
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK  = 7'h7F;
    localparam int   MAX_DIGITS = 8;

    // Segments a..g on bits 6..0, active low (common-anode display).
    function automatic seg_t hex_to_seg_n(input logic [3:0] nibble);
        seg_t s;
        case (nibble)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seven_segment_mux_driver_if.sv
// rtl/seven_segment_mux_driver_if.sv - value/strobe inputs and display pin outputs of the mux driver
interface seven_segment_mux_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (
        output en, load, value, dp, blank,
        input  seg_n, dp_n, an_n, frame_done
    );

    modport slave (
        input  en, load, value, dp, blank,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/seven_segment_mux_driver_hex_decode.sv
// rtl/seven_segment_mux_driver_hex_decode.sv - combinational nibble to active-low segment decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_n_o
);

    assign seg_n_o = hex_to_seg_n(nibble_i);

endmodule

// File: rtl/seven_segment_mux_driver.sv
// rtl/seven_segment_mux_driver.sv - multiplexed common-anode hex display driver with frame-synchronous update
module seven_segment_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEADTIME    = 16,
    parameter int LZ_BLANK    = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    seven_segment_mux_driver_if.slave  bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tc, wrap;

    logic [VAL_W-1:0]      pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic                  pend_valid_q, pend_valid_d;

    logic [VAL_W-1:0]      disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;

    logic [NUM_DIGITS-1:0] lz_mask, dark;
    logic [3:0]            sel_nib;
    logic                  sel_dark, sel_dp;
    seg_t                  dec_seg;

    seg_t                  seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    // Scan position: counter within a digit slot, index of the slot.
    always_comb begin
        tc    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        wrap  = bus.en && tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d = '0;
        idx_d = '0;
        if (bus.en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
            idx_d = idx_q;
            if (tc) begin
                idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    // A load landing on the wrap edge goes straight to display; otherwise
    // display only ever changes at a frame boundary.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        if (bus.load && wrap) begin
            disp_val_d   = bus.value;
            disp_dp_d    = bus.dp;
            disp_blank_d = bus.blank;
            pend_valid_d = 1'b0;
        end else begin
            if (wrap && pend_valid_q) begin
                disp_val_d   = pend_val_q;
                disp_dp_d    = pend_dp_q;
                disp_blank_d = pend_blank_q;
                pend_valid_d = 1'b0;
            end
            if (bus.load) begin
                pend_val_d   = bus.value;
                pend_dp_d    = bus.dp;
                pend_blank_d = bus.blank;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Leading-zero mask, scanned from the most significant digit down; digit 0 is never masked.
    always_comb begin
        logic higher_zero;
        logic nib_zero;
        higher_zero = 1'b1;
        lz_mask     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib_zero    = (disp_val_q[i*4 +: 4] == 4'h0);
            lz_mask[i]  = (i > 0) && nib_zero && higher_zero;
            higher_zero = higher_zero && nib_zero;
        end
        dark = disp_blank_q | ((LZ_BLANK != 0) ? lz_mask : '0);
    end

    always_comb begin
        sel_nib  = 4'h0;
        sel_dark = 1'b1;
        sel_dp   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib  = disp_val_q[i*4 +: 4];
                sel_dark = dark[i];
                sel_dp   = disp_dp_q[i];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (sel_nib),
        .seg_n_o  (dec_seg)
    );

    // Segments and anode come from the same registered slot, so they switch together.
    always_comb begin
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
        an_d   = '1;
        fd_d   = 1'b0;
        if (bus.en) begin
            fd_d   = wrap;
            seg_d  = sel_dark ? SEG_BLANK : dec_seg;
            dp_n_d = sel_dark || !sel_dp;
            if (cnt_q >= CNT_W'(DEADTIME)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        an_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_q         <= '1;
            fd_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// tb/tb_seven_segment_mux_driver.sv - scoreboard bench for seven_segment_mux_driver
module tb_seven_segment_mux_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
    } slot_t;

    logic clk;
    logic reset_n;

    seven_segment_mux_driver_if #(.NUM_DIGITS(4)) m_if ();
    seven_segment_mux_driver_if #(.NUM_DIGITS(4)) l_if ();

    seven_segment_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEADTIME(1), .LZ_BLANK(0)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (m_if.slave)
    );

    seven_segment_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .DEADTIME(1), .LZ_BLANK(1)
    ) u_dut_lz (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (l_if.slave)
    );

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    slot_t      q0 [$];
    slot_t      q1 [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] prev_an [2];
    int         run_len [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int m, input logic [15:0] v, input logic [3:0] dpv,
                              input logic [3:0] bl, input bit lz);
        logic [3:0] drk;
        bit         hz;
        slot_t      e;
        hz  = 1'b1;
        drk = bl;
        for (int i = 3; i >= 0; i--) begin
            if (lz && i > 0 && hz && v[i*4 +: 4] == 4'h0) drk[i] = 1'b1;
            hz = hz && (v[i*4 +: 4] == 4'h0);
        end
        for (int i = 0; i < 4; i++) begin
            e.an    = 4'hF;
            e.an[i] = 1'b0;
            e.seg   = drk[i] ? 7'h7F : seg_tab[v[i*4 +: 4]];
            e.dp_n  = drk[i] ? 1'b1 : ~dpv[i];
            if (m == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Called once per falling edge: pops an expectation at the start of each lit slot.
    task automatic mon_step(input int m, input logic rst_ok, input logic [3:0] an,
                            input logic [6:0] seg, input logic dpn);
        slot_t e;
        if (!rst_ok) begin
            prev_an[m] = 4'hF;
            run_len[m] = 0;
            return;
        end
        if (an != prev_an[m] && prev_an[m] != 4'hF) check("slot_len", run_len[m], 3);
        if (an != 4'hF) begin
            if (an != prev_an[m]) begin
                run_len[m] = 1;
                if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_slot: dut %0d got an_n %b expected none", m, an);
                end else begin
                    if (m == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check("slot_an", an, e.an);
                    check("slot_seg", seg, e.seg);
                    check("slot_dp", dpn, e.dp_n);
                end
            end else begin
                run_len[m]++;
            end
        end
        prev_an[m] = an;
    endtask

    always @(negedge clk) mon_step(0, reset_n, m_if.an_n, m_if.seg_n, m_if.dp_n);
    always @(negedge clk) mon_step(1, reset_n, l_if.an_n, l_if.seg_n, l_if.dp_n);

    task automatic wait_frame(input int m, input bit chk16);
        int   n;
        logic fd;
        n = 0;
        do begin
            tick();
            n++;
            fd = (m == 0) ? m_if.frame_done : l_if.frame_done;
        end while (fd !== 1'b1 && n < 64);
        check("frame_done_seen", fd, 1);
        if (chk16) check("frame_period", n, 16);
    endtask

    task automatic do_load(input int m, input logic [15:0] v, input logic [3:0] dpv,
                           input logic [3:0] bl);
        if (m == 0) begin
            m_if.value = v; m_if.dp = dpv; m_if.blank = bl; m_if.load = 1'b1;
            tick();
            m_if.load = 1'b0;
        end else begin
            l_if.value = v; l_if.dp = dpv; l_if.blank = bl; l_if.load = 1'b1;
            tick();
            l_if.load = 1'b0;
        end
    endtask

    initial begin
        prev_an[0] = 4'hF; prev_an[1] = 4'hF;
        run_len[0] = 0;    run_len[1] = 0;
        reset_n = 1'b0;
        m_if.en = 1'b0; m_if.load = 1'b0; m_if.value = '0; m_if.dp = '0; m_if.blank = '0;
        l_if.en = 1'b0; l_if.load = 1'b0; l_if.value = '0; l_if.dp = '0; l_if.blank = '0;
        tick();
        tick();
        check("reset_seg", m_if.seg_n, 7'h7F);
        check("reset_an", m_if.an_n, 4'hF);
        check("reset_dp", m_if.dp_n, 1'b1);
        check("reset_fd", m_if.frame_done, 1'b0);
        check("reset_an_lz", l_if.an_n, 4'hF);
        reset_n = 1'b1;
        tick();

        // Scan: first frame shows the cleared display, loaded value follows at the boundary.
        do_load(0, 16'h12AF, 4'b0000, 4'b0000);
        push_frame(0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
        push_frame(0, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
        m_if.en = 1'b1;
        wait_frame(0, 1'b1);
        wait_frame(0, 1'b1);

        // Tear-free mid-frame load.
        push_frame(0, 16'h12AF, 4'b0000, 4'b0000, 1'b0);
        push_frame(0, 16'h1234, 4'b0000, 4'b0000, 1'b0);
        repeat (5) tick();
        do_load(0, 16'h1234, 4'b0000, 4'b0000);
        wait_frame(0, 1'b0);
        wait_frame(0, 1'b1);

        // Two loads in one frame: last wins.
        push_frame(0, 16'h1234, 4'b0000, 4'b0000, 1'b0);
        push_frame(0, 16'h5678, 4'b0000, 4'b0000, 1'b0);
        repeat (3) tick();
        do_load(0, 16'h9ABC, 4'b0000, 4'b0000);
        repeat (4) tick();
        do_load(0, 16'h5678, 4'b0000, 4'b0000);
        wait_frame(0, 1'b0);
        wait_frame(0, 1'b1);

        // Load on the wrap edge bypasses pending.
        push_frame(0, 16'h5678, 4'b0000, 4'b0000, 1'b0);
        push_frame(0, 16'hDEF0, 4'b0000, 4'b0000, 1'b0);
        repeat (15) tick();
        m_if.value = 16'hDEF0; m_if.load = 1'b1;
        tick();
        m_if.load = 1'b0;
        check("collision_fd", m_if.frame_done, 1'b1);
        wait_frame(0, 1'b1);

        // dp / blank masking.
        push_frame(0, 16'hDEF0, 4'b0000, 4'b0000, 1'b0);
        push_frame(0, 16'h4321, 4'b0100, 4'b0001, 1'b0);
        repeat (6) tick();
        do_load(0, 16'h4321, 4'b0100, 4'b0001);
        wait_frame(0, 1'b0);
        wait_frame(0, 1'b1);

        // Enable off/on, load accepted while disabled.
        m_if.en = 1'b0;
        tick();
        check("en_off_an", m_if.an_n, 4'hF);
        check("en_off_seg", m_if.seg_n, 7'h7F);
        do_load(0, 16'h8421, 4'b0000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("en_off_hold_an", m_if.an_n, 4'hF);
            check("en_off_hold_fd", m_if.frame_done, 1'b0);
        end
        push_frame(0, 16'h4321, 4'b0100, 4'b0001, 1'b0);
        push_frame(0, 16'h8421, 4'b0000, 4'b0000, 1'b0);
        m_if.en = 1'b1;
        tick();
        check("en_on_deadtime", m_if.an_n, 4'hF);
        tick();
        check("en_on_first", m_if.an_n, 4'b1110);
        wait_frame(0, 1'b0);
        wait_frame(0, 1'b1);

        // Asynchronous reset in the middle of slot 0.
        q0.push_back('{an: 4'b1110, seg: 7'b1001111, dp_n: 1'b1});
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("async_rst_seg", m_if.seg_n, 7'h7F);
        check("async_rst_an", m_if.an_n, 4'hF);
        check("async_rst_dp", m_if.dp_n, 1'b1);
        check("async_rst_fd", m_if.frame_done, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        push_frame(0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
        wait_frame(0, 1'b1);
        m_if.en = 1'b0;

        // Leading-zero suppression instance.
        do_load(1, 16'h0050, 4'b0000, 4'b0000);
        push_frame(1, 16'h0000, 4'b0000, 4'b0000, 1'b1);
        push_frame(1, 16'h0050, 4'b0000, 4'b0000, 1'b1);
        l_if.en = 1'b1;
        wait_frame(1, 1'b1);
        wait_frame(1, 1'b1);
        l_if.en = 1'b0;
        repeat (3) tick();
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
